// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store unit
// and a DMA/loader requester. One access per grant; the 1-cycle-latency
// read data is routed back to whichever requester issued the read.
// Optional per-requester grant/conflict statistics: define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CPU_PRIO = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    // CPU load/store unit
    input  logic                c_req,
    input  logic                c_we,
    input  logic [DATA_W/8-1:0] c_be,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    // DMA / loader
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // data memory port
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]         stat_c_grants,
    output logic [15:0]         stat_d_grants,
    output logic [15:0]         stat_conflicts
`endif
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    req_t       last_q, last_d;
    logic [3:0] wait_q, wait_d;
    owner_t     own_q, own_d;
    logic       c_win, d_win;

    // Winner selection; nothing is granted while reset is held
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (reset_n) begin
            if (c_req && d_req) begin
                if (CPU_PRIO != 0) begin
                    if (wait_q == WAIT_MAX) d_win = 1'b1;
                    else                    c_win = 1'b1;
                end else begin
                    if (last_q == REQ_DMA) c_win = 1'b1;
                    else                   d_win = 1'b1;
                end
            end else if (c_req) begin
                c_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    // Memory port mux from the winner; all zero when idle
    always_comb begin
        c_gnt     = c_win;
        d_gnt     = d_win;
        mem_en    = c_win | d_win;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_win) begin
            mem_we    = c_we;
            mem_be    = c_be;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (d_win) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Next arbitration state: last winner, DMA starvation counter, read owner
    always_comb begin
        last_d = last_q;
        if (c_win)      last_d = REQ_CPU;
        else if (d_win) last_d = REQ_DMA;

        wait_d = wait_q;
        if ((CPU_PRIO == 0) || !d_req || d_win) wait_d = '0;
        else if (wait_q != WAIT_MAX)            wait_d = wait_q + 4'd1;

        own_d = OWN_NONE;
        if (c_win && !c_we)      own_d = OWN_CPU;
        else if (d_win && !d_we) own_d = OWN_DMA;
    end

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= REQ_DMA;
            wait_q <= '0;
            own_q  <= OWN_NONE;
        end else begin
            last_q <= last_d;
            wait_q <= wait_d;
            own_q  <= own_d;
        end
    end

    // Read return routing; a return pending across reset is suppressed
    always_comb begin
        c_rvalid = reset_n && (own_q == OWN_CPU);
        d_rvalid = reset_n && (own_q == OWN_DMA);
        c_rdata  = c_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating grant and conflict counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_c_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (c_win && (stat_c_grants != '1))             stat_c_grants  <= stat_c_grants + 16'd1;
            if (d_win && (stat_d_grants != '1))             stat_d_grants  <= stat_d_grants + 16'd1;
            if (c_req && d_req && (stat_conflicts != '1))   stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a CPU-priority instance (u_dut, with a small
// byte-enabled memory) and a round-robin instance (u_rr) share the stimulus.
// Read returns are checked through per-requester scoreboard queues.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        c_req, c_we, d_req, d_we;
    logic [3:0]  c_be, d_be;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        rc_gnt, rc_rvalid, rd_gnt, rd_rvalid, rm_en, rm_we;
    logic [3:0]  rm_be;
    logic [31:0] rc_rdata, rd_rdata, rm_addr, rm_wdata, rm_rdata;
    assign rm_rdata = '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] st_c, st_d, st_x, rst_c, rst_d, rst_x;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CPU_PRIO(1), .MAX_WAIT(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_c_grants(st_c), .stat_d_grants(st_d), .stat_conflicts(st_x)
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CPU_PRIO(0), .MAX_WAIT(4)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(rc_gnt), .c_rvalid(rc_rvalid), .c_rdata(rc_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(rd_gnt), .d_rvalid(rd_rvalid), .d_rdata(rd_rdata),
        .mem_en(rm_en), .mem_we(rm_we), .mem_be(rm_be), .mem_addr(rm_addr),
        .mem_wdata(rm_wdata), .mem_rdata(rm_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_c_grants(rst_c), .stat_d_grants(rst_d), .stat_conflicts(rst_x)
`endif
    );

    // Byte-enabled data memory with one cycle of read latency
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t c_q[$];
    exp_t d_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare read returns against the scoreboard for the current cycle
    task automatic check_returns();
        exp_t e;
        if (c_q.size() > 0 && c_q[0].due == cyc_n) begin
            e = c_q.pop_front();
            chk("c_rvalid", {31'b0, c_rvalid}, 32'd1);
            chk("c_rdata", c_rdata, e.data);
        end else begin
            chk("c_rvalid_idle", {31'b0, c_rvalid}, 32'd0);
            chk("c_rdata_idle", c_rdata, 32'd0);
        end
        if (d_q.size() > 0 && d_q[0].due == cyc_n) begin
            e = d_q.pop_front();
            chk("d_rvalid", {31'b0, d_rvalid}, 32'd1);
            chk("d_rdata", d_rdata, e.data);
        end else begin
            chk("d_rvalid_idle", {31'b0, d_rvalid}, 32'd0);
            chk("d_rdata_idle", d_rdata, 32'd0);
        end
    endtask

    // Advance one cycle: check returns mid-cycle, end just after the next edge
    task automatic tick();
        @(negedge clk);
        check_returns();
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ctl"}, {12'b0, c_gnt, d_gnt, rc_gnt, rd_gnt, c_rvalid, d_rvalid,
                            rc_rvalid, rd_rvalid, mem_en, rm_en, mem_we, rm_we, mem_be, rm_be}, 32'd0);
        chk({tag, "_c_rdata"}, c_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rr_rdata"}, rc_rdata | rd_rdata, 32'd0);
        chk({tag, "_rr_addr"}, rm_addr, 32'd0);
        chk({tag, "_rr_wdata"}, rm_wdata, 32'd0);
    endtask

    task automatic stats_zero(input string tag);
`ifdef DMEM_ARB_STATS_EN
        chk({tag, "_stats"}, {st_c | rst_c, st_d | rst_d}, 32'd0);
        chk({tag, "_stat_x"}, {16'b0, st_x | rst_x}, 32'd0);
`else
        chk({tag, "_no_rvalid"}, {30'b0, c_rvalid, d_rvalid}, 32'd0);
`endif
    endtask

    // One access by a single requester (the other's req is dropped); expects
    // an immediate grant and pushes the expected read data for a read
    task automatic access(input bit is_d, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input string tag);
        int waited;
        bit got;
        exp_t e;
        waited = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; c_req = 1'b0;
        end else begin
            c_req = 1'b1; c_we = we; c_be = be; c_addr = addr; c_wdata = wdata; d_req = 1'b0;
        end
        #1;
        got = is_d ? d_gnt : c_gnt;
        while (!got && waited < 20) begin
            tick();
            waited++;
            got = is_d ? d_gnt : c_gnt;
        end
        chk({tag, "_gnt"}, {31'b0, got}, 32'd1);
        chk({tag, "_wait"}, waited, 32'd0);
        if (got) begin
            chk({tag, "_mem_addr"}, mem_addr, addr);
            chk({tag, "_mem_ctl"}, {27'b0, mem_en, mem_we, mem_be}, {27'b0, 1'b1, we, be});
            if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
            else begin
                e.due  = cyc_n + 1;
                e.data = exp_rd;
                if (is_d) d_q.push_back(e);
                else      c_q.push_back(e);
            end
        end
        tick();
    endtask

    task automatic idle();
        c_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    logic [9:0] prio_pat;
    logic [9:0] rr_pat;

    initial begin
        prio_pat = 10'b10_0001_0000;   // bit i set = DMA wins cycle i
        rr_pat   = 10'b10_1010_1010;

        // Reset with both requesting and non-zero fields: everything stays 0
        reset_n = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_be = 4'hF; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
        tick();
        tick();
        reset_check("rst0");
        stats_zero("rst0");

        // Both requesting continuously from reset (be=0 writes leave memory intact)
        reset_n = 1'b1;
        c_be = 4'h0; d_be = 4'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("prio_gnt%0d", i), {30'b0, c_gnt, d_gnt}, prio_pat[i] ? 32'd1 : 32'd2);
            chk($sformatf("rr_gnt%0d", i), {30'b0, rc_gnt, rd_gnt}, rr_pat[i] ? 32'd1 : 32'd2);
            tick();
        end
`ifdef DMEM_ARB_STATS_EN
        chk("stat_prio", {st_c, st_d}, {16'd8, 16'd2});
        chk("stat_conf", {16'b0, st_x}, 32'd10);
        chk("stat_rr", {rst_c, rst_d}, {16'd5, 16'd5});
`endif

        // No request: memory port fully quiet
        c_req = 1'b0; d_req = 1'b0;
        #1;
        chk("idle_ctl", {26'b0, c_gnt, d_gnt, mem_en, mem_we, mem_be}, 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        tick();

        // DMA fill: 16 back-to-back writes of the 0xFE pattern
        for (int i = 0; i < 16; i++)
            access(1'b1, 1'b1, 4'hF, 32'(i * 4), 32'hFEFEFEFE, 32'd0, $sformatf("fill%0d", i));
        idle();
        for (int i = 0; i < 16; i++)
            chk($sformatf("fill_mem%0d", i), mem[i], 32'hFEFEFEFE);

        // Solo CPU read after the fill
        access(1'b0, 1'b0, 4'hF, 32'h0, 32'd0, 32'hFEFEFEFE, "c_rd0");
        idle();

        // Write then read the same address in consecutive grants; partial write
        access(1'b1, 1'b1, 4'hF, 32'h8, 32'h12345678, 32'd0, "d_wr8");
        access(1'b0, 1'b0, 4'hF, 32'h8, 32'd0, 32'h12345678, "c_rd8_raw");
        access(1'b0, 1'b1, 4'b0011, 32'h4, 32'h0000BEEF, 32'd0, "c_wr4_part");

        // Pipelined reads alternating between owners
        access(1'b0, 1'b0, 4'hF, 32'h4, 32'd0, 32'hFEFEBEEF, "c_rd4a");
        access(1'b1, 1'b0, 4'hF, 32'h8, 32'd0, 32'h12345678, "d_rd8a");
        access(1'b0, 1'b0, 4'hF, 32'h4, 32'd0, 32'hFEFEBEEF, "c_rd4b");
        access(1'b1, 1'b0, 4'hF, 32'h8, 32'd0, 32'h12345678, "d_rd8b");
        idle();
        idle();
        chk("sb_drained", c_q.size() + d_q.size(), 32'd0);

        // Read granted, then reset for one cycle: its return must vanish
        c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = 32'h0; d_req = 1'b0;
        #1;
        chk("drop_gnt", {31'b0, c_gnt}, 32'd1);
        tick();
        reset_n = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_be = 4'h0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h0;
        #1;
        reset_check("rst_drop");
        tick();
        stats_zero("rst_drop");
        reset_n = 1'b1;
        #1;
        chk("tie_after_rst", {30'b0, c_gnt, d_gnt}, 32'd2);
        chk("rr_tie_after_rst", {30'b0, rc_gnt, rd_gnt}, 32'd2);
        tick();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (byte-addressed, 32-bit word access) between the CPU load/store unit and a DMA/loader requester.
- The DMA requester bulk-fills or inspects memory, for example writing a 0xFEFE pattern, while the CPU runs.
- Sits between the CPU datapath and the data memory.
- Performs one access per grant: arbitrates, drives the memory port, and routes the 1-cycle-latency read data back to the winning requester.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte-enable width is DATA_W/8.
- CPU_PRIO, 1: 1 = CPU fixed priority with a starvation guard; 0 = pure round-robin.
- MAX_WAIT, 4: in CPU_PRIO=1 mode, the number of consecutive losing cycles after which DMA is forced to win. Range 1..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- c_req  in  1  CPU access request; held until granted.
- c_we  in  1  CPU write enable.
- c_be  in  DATA_W/8  CPU byte enables.
- c_addr  in  ADDR_W  CPU byte address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU granted this cycle.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  DATA_W  CPU read data.
- d_req, d_we, d_be, d_addr, d_wdata  in  same widths as the CPU inputs  DMA request fields.
- d_gnt, d_rvalid, d_rdata  out  same widths as the CPU outputs  DMA grant and read return.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read access.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-low on `reset_n`.
- Reset state: `last`=DMA, `wait_cnt`=0, `rd_owner`=none. While reset_n=0, all of these are 0: gnt, rvalid, mem_en, mem_we, mem_be, mem_addr, mem_wdata.
- Grant decision: combinational from c_req/d_req and registered state.
  - At most one gnt per cycle.
  - gnt and mem_en are asserted in the same cycle.
  - mem_* are muxed from the winner.
  - With no request: mem_en=0 and the remaining mem_* outputs are 0.
- Handshake: each gnt pulse accepts exactly one access. The requester must keep its req and fields stable until it sees gnt. To issue back-to-back accesses, the requester holds req high with new fields on the cycle after gnt.
- Arbitration when both request:
  - CPU_PRIO=0: the requester other than `last` wins. `last` is updated to the winner on every grant.
  - CPU_PRIO=1: CPU wins unless wait_cnt==MAX_WAIT, in which case DMA wins.
- wait_cnt (CPU_PRIO=1 mode only):
  - Increments, saturating at MAX_WAIT, each cycle d_req=1 and DMA is not granted.
  - Clears on any DMA grant, or whenever d_req=0.
- Single requester: always granted immediately; zero wait cycles.
- Read return:
  - A granted read (we=0) sets `rd_owner` to the winner.
  - Next cycle: that requester's rvalid=1 and its rdata=mem_rdata.
  - The other requester's rvalid=0 and its rdata=0.
  - Writes produce no rvalid.
  - Read throughput: one read return per cycle; pipelined reads from alternating owners route correctly.
- Boundary cases:
  - Reset asserted the cycle after a read grant: the pending rvalid is dropped, and no rvalid appears after reset deasserts.
  - Simultaneous first requests after reset: CPU wins, because `last`=DMA.
  - Addresses pass through unchanged; no alignment check.
  - A write and a read to the same address in consecutive grants: the read sees the new data, as ordered by the memory.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_c_grants (16), stat_d_grants (16) and stat_conflicts (16).
  - Each is a saturating counter, cleared by reset.
  - stat_c_grants and stat_d_grants count grants per requester.
  - stat_conflicts counts cycles with c_req && d_req.
- When undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Solo DMA, 16 back-to-back writes of 0xFEFEFEFE (be=4'hF) to addr 0x0..0x3C: 16 consecutive d_gnt; bytes 0..63 read 0xFE.
- Solo CPU read of addr 0x0 after the fill: c_gnt in cycle N; c_rvalid=1 with c_rdata=0xFEFEFEFE in N+1; d_rvalid stays 0.
- CPU_PRIO=0, both requesting continuously for 6 cycles from reset: grants C,D,C,D,C,D.
- CPU_PRIO=1, MAX_WAIT=4, both requesting continuously: grants C,C,C,C,D,C,C,C,C,D; the DMA never waits more than 4 cycles.
- Interleaved reads (CPU addr 0x4, DMA addr 0x8, 0x8 preloaded with 0x12345678): each rvalid lands only on its owner with the correct data one cycle after its grant.
- Read granted, then reset_n=0 for 1 cycle: no rvalid is emitted, and all outputs are 0 during reset; the next tie goes to CPU. With DMEM_ARB_STATS_EN defined, the counters read 0.
